// File: rtl/mash_modulator.sv
// mash_modulator: MASH delta-sigma modulator with runtime order select, enable, fraction load and LSB dither
module mash_modulator #(
  parameter int WIDTH = 16,
  parameter int ORDER = 3,
  parameter logic [14:0] LFSR_SEED = 15'h0001,
  localparam int OUT_W = ORDER + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] frac_in,
  input  logic             frac_load,
  input  logic [1:0]       order_sel,
  input  logic             dither_en,
  output logic [OUT_W-1:0] y_out,
  output logic             y_valid,
  output logic [ORDER-1:0] carry_out
);
  logic [WIDTH-1:0] frac_q, in_w;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] acc [ORDER];
  logic [WIDTH-1:0] acc_nx [ORDER];
  logic [ORDER-1:0] act, c, h1, h2, h3;
  logic [2:0] req;
  logic [14:0] lfsr;
  logic [OUT_W-1:0] y;

  function automatic logic [OUT_W-1:0] z(input logic b);
    return {{(OUT_W-1){1'b0}}, b};
  endfunction

  // NCN term of stage k is c*(1-D)^k, so history weights are binomial coefficients
  always_comb begin
    req = {1'b0, order_sel} + 3'd1;
    in_w = frac_q + {{(WIDTH-1){1'b0}}, dither_en & lfsr[0]};
    sum = '0;
    y = '0;
    for (int k = 0; k < ORDER; k++) begin
      act[k] = 3'(k) < req;
      sum = {1'b0, acc[k]} + {1'b0, in_w};
      c[k] = act[k] & sum[WIDTH];
      acc_nx[k] = act[k] ? sum[WIDTH-1:0] : '0;
      in_w = sum[WIDTH-1:0];
      y = y + z(c[k]) - OUT_W'(k) * z(h1[k]) + OUT_W'(k * (k - 1) / 2) * z(h2[k])
            - OUT_W'(k * (k - 1) * (k - 2) / 6) * z(h3[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q <= '0;
      y_out <= '0;
      y_valid <= 1'b0;
      carry_out <= '0;
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
      lfsr <= LFSR_SEED;
      for (int k = 0; k < ORDER; k++) acc[k] <= '0;
    end else begin
      if (frac_load) frac_q <= frac_in;
      y_valid <= en;
      for (int k = 0; k < ORDER; k++) acc[k] <= en ? acc_nx[k] : (act[k] ? acc[k] : '0);
      h1 <= (en ? c : h1) & act;
      h2 <= (en ? h1 : h2) & act;
      h3 <= (en ? h2 : h3) & act;
      if (en) begin
        lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        y_out <= y;
        carry_out <= c;
      end
    end
  end
endmodule
